// File: rtl/sw_input_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sw_input_port : slide-switch peripheral (sync, debounce, sticky rise events)
// Rev 1.0
// ============================================================================
module sw_input_port #(
  parameter int         WIDTH     = 8,
  parameter int         DB_LIMIT  = 50000,
  parameter int         CNT_W     = 16,
  parameter logic [8:0] SW_ADDR   = 9'h140,
  parameter logic [8:0] STAT_ADDR = 9'h141
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [1:0]       mem_cmd,
  input  logic [8:0]       mem_addr,
  output logic             rd_en,
  output logic [15:0]      rd_data,
  output logic             irq
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SETTLE = 1'b1;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] new_events;
  logic             sw_rd, stat_rd;

  assign sw_rd   = (mem_cmd == 2'b01) && (mem_addr == SW_ADDR);
  assign stat_rd = (mem_cmd == 2'b01) && (mem_addr == STAT_ADDR);
  assign rd_en   = sw_rd | stat_rd;
  assign rd_data = sw_rd   ? 16'(stable_q) :
                   stat_rd ? 16'(status_q) : 16'h0000;
  assign irq     = |status_q;

  // Whole vector debounced as one: any bit differing from the candidate restarts the count.
  always_comb begin
    stable_d   = stable_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    new_events = '0;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q != stable_q) begin
          cand_d  = sync2_q;
          cnt_d   = CNT_W'(1);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (sync2_q == stable_q) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = CNT_W'(1);
        end else if (cnt_q == CNT_W'(DB_LIMIT - 1)) begin
          stable_d   = cand_q;
          new_events = cand_q & ~stable_q;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    // An event accepted on the clearing edge survives the clear.
    status_d = (stat_rd ? '0 : status_q) | new_events;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cand_q   <= '0;
      status_q <= '0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
    end else begin
      sync1_q  <= sw_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cand_q   <= cand_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sw_input_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sw_input_port : directed + randomized checks against a history-based model
// Rev 1.0
// ============================================================================
module tb_sw_input_port;

  localparam int         DB   = 4;
  localparam logic [8:0] A_SW = 9'h140;
  localparam logic [8:0] A_ST = 9'h141;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic [7:0]  sw_in    = 8'h00;
  logic [1:0]  mem_cmd  = 2'b00;
  logic [8:0]  mem_addr = 9'h000;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  sw_input_port #(
    .WIDTH    (8),
    .DB_LIMIT (DB),
    .CNT_W    (16),
    .SW_ADDR  (A_SW),
    .STAT_ADDR(A_ST)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_in   (sw_in),
    .mem_cmd (mem_cmd),
    .mem_addr(mem_addr),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: synchronizer as a two-sample delay; stable takes a value once the last DB
  // synchronized samples all agree on it.
  logic [7:0] m_sync1 = '0, m_sync2 = '0, m_stable = '0, m_status = '0;
  logic [7:0] hist [DB];
  int         nvalid = 0;
  logic [7:0] m_s, m_ev;
  bit         m_same;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_sync1 = '0; m_sync2 = '0; m_stable = '0; m_status = '0; nvalid = 0;
      end else begin
        m_s = m_sync2;
        for (int i = DB - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = m_s;
        if (nvalid < DB) nvalid++;
        m_same = 1'b1;
        for (int i = 0; i < DB; i++) if (hist[i] != m_s) m_same = 1'b0;
        m_ev = '0;
        if (nvalid == DB && m_same && m_s != m_stable) begin
          m_ev     = m_s & ~m_stable;
          m_stable = m_s;
        end
        if (mem_cmd == 2'b01 && mem_addr == A_ST) m_status = '0;
        m_status = m_status | m_ev;
        m_sync2 = m_sync1;
        m_sync1 = sw_in;
      end
    end
  end

  initial begin
    logic        e_en;
    logic [15:0] e_data;
    forever begin
      @(negedge clk);
      e_en   = (mem_cmd == 2'b01) && (mem_addr == A_SW || mem_addr == A_ST);
      e_data = !e_en ? 16'h0000 : (mem_addr == A_SW) ? {8'h00, m_stable} : {8'h00, m_status};
      chk("cmp_rd_en", {15'b0, rd_en}, {15'b0, e_en});
      chk("cmp_rd_data", rd_data, e_data);
      chk("cmp_irq", {15'b0, irq}, {15'b0, |m_status});
    end
  end

  initial begin
    int  hold;
    int  r;
    bit  seen;

    step(3);
    reset = 1'b0;
    step(2);
    mem_cmd = 2'b01; mem_addr = A_SW; #1;
    chk("reset_rd_en", {15'b0, rd_en}, 16'h0001);
    chk("reset_sw", rd_data, 16'h0000);
    chk("reset_irq", {15'b0, irq}, 16'h0000);
    mem_cmd = 2'b00;

    // reset in the middle of a settle
    step(1);
    sw_in = 8'h3C;
    step(5);
    reset = 1'b1; sw_in = 8'h00; mem_cmd = 2'b01; mem_addr = A_SW; #1;
    chk("t1_reset_sw", rd_data, 16'h0000);
    chk("t1_reset_irq", {15'b0, irq}, 16'h0000);
    mem_cmd = 2'b00;
    step(2);
    reset = 1'b0;
    step(10);
    mem_cmd = 2'b01; mem_addr = A_SW; #1;
    chk("t1_after_sw", rd_data, 16'h0000);
    mem_addr = A_ST; #1;
    chk("t1_after_stat", rd_data, 16'h0000);
    mem_cmd = 2'b00;

    // 0x00 -> 0xA5 accepted at edge 5, not edge 4
    step(1);
    sw_in = 8'hA5;
    step(5);
    mem_cmd = 2'b01; mem_addr = A_SW; #1;
    chk("t2_edge4", rd_data, 16'h0000);
    mem_cmd = 2'b00;
    step(1);
    mem_cmd = 2'b01; mem_addr = A_SW; #1;
    chk("t2_edge5", rd_data, 16'h00A5);
    chk("t2_irq", {15'b0, irq}, 16'h0001);

    // address decode
    chk("t5_rd_en", {15'b0, rd_en}, 16'h0001);
    mem_addr = 9'h100; #1;
    chk("t5_other_en", {15'b0, rd_en}, 16'h0000);
    chk("t5_other_data", rd_data, 16'h0000);
    mem_cmd = 2'b10; mem_addr = A_ST; #1;
    chk("t5_write_en", {15'b0, rd_en}, 16'h0000);
    chk("t5_write_data", rd_data, 16'h0000);

    // clear on read
    mem_cmd = 2'b01; mem_addr = A_ST; #1;
    chk("t6_stat", rd_data, 16'h00A5);
    step(1);
    #1;
    chk("t6_stat_cleared", rd_data, 16'h0000);
    mem_cmd = 2'b00;
    chk("t6_irq_low", {15'b0, irq}, 16'h0000);

    // short bounce rejected
    step(1);
    sw_in = 8'hA4;
    step(2);
    sw_in = 8'hA5;
    step(12);
    mem_cmd = 2'b01; mem_addr = A_SW; #1;
    chk("t3_sw", rd_data, 16'h00A5);
    chk("t3_irq", {15'b0, irq}, 16'h0000);
    mem_cmd = 2'b00;

    // candidate restart: intermediate 0xA7 never becomes stable
    step(1);
    sw_in = 8'hA7;
    step(2);
    sw_in = 8'hAF;
    seen = 1'b0;
    mem_cmd = 2'b01; mem_addr = A_SW;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (rd_data == 16'h00A7) seen = 1'b1;
      step(1);
    end
    #1;
    chk("t4_sw", rd_data, 16'h00AF);
    chk("t4_no_a7", {15'b0, seen}, 16'h0000);
    mem_cmd = 2'b00;

    // bit-6 rise accepted on the same edge as a status read
    sw_in = 8'hEF;
    step(5);
    mem_cmd = 2'b01; mem_addr = A_ST; #1;
    chk("t6b_pre", rd_data, 16'h000A);
    step(1);
    #1;
    chk("t6b_event_wins", rd_data, 16'h0040);
    mem_cmd = 2'b00;
    chk("t6b_irq", {15'b0, irq}, 16'h0001);
    mem_cmd = 2'b01; mem_addr = A_ST;
    step(1);
    mem_cmd = 2'b00; #1;
    chk("t6b_irq_clear", {15'b0, irq}, 16'h0000);

    // randomized traffic with bounce, reads, writes and occasional resets
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      step(1);
      if (hold == 0) begin
        if ($urandom_range(0, 1) == 0) sw_in = 8'($urandom);
        else sw_in = sw_in ^ (8'h01 << $urandom_range(0, 7));
        hold = $urandom_range(1, 10);
      end
      hold--;
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    begin mem_cmd = 2'b01; mem_addr = A_SW; end
        2, 3:    begin mem_cmd = 2'b01; mem_addr = A_ST; end
        4:       begin mem_cmd = 2'b10; mem_addr = ($urandom_range(0, 1) == 0) ? A_SW : A_ST; end
        5:       begin mem_cmd = 2'b01; mem_addr = 9'($urandom); end
        default: begin mem_cmd = 2'($urandom); mem_addr = 9'h000; end
      endcase
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1; mem_cmd = 2'b00;
      end else begin
        reset = 1'b0;
      end
    end
    reset = 1'b0; mem_cmd = 2'b00;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
